down_counter_timer: RTL and testbench

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

---
 rtl/down_counter_timer.sv | 124 ++++++++++++
 tb/tb_down_counter_timer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Programmable down-counting timer with optional auto-reload.
//
// A load captures load_val into both the live count and a reload register
// and parks the timer in IDLE. start launches the countdown, pause (level)
// freezes it, and expiry raises a one-cycle done pulse. With AUTO_RELOAD=1
// expiry restarts from the reload register instead of stopping in DONE.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     synchronous active-high reset
//   load      capture load_val into count and reload register
//   load_val  value captured on load
//   start     begin/restart countdown
//   pause     hold count while high
//   count     registered current count
//   state     registered FSM state (IDLE=00, RUN=01, PAUSE=10, DONE=11)
//   busy      state is RUN or PAUSE (decode of registered state)
//   zero      count == 0 (decode of registered count)
//   done      registered one-cycle expiry pulse
module down_counter_timer #(
  parameter int unsigned WIDTH       = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  // State, count, reload and done registers; reset beats everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: load overrides every FSM transition.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A zero count has nothing to time, so start is ignored.
          if (start && (count_q != '0)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
            if (AUTO_RELOAD) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = EXPIRED;
            end
          end else begin
            // Unreachable with a nonzero start count; never decrement past 0.
            state_d = EXPIRED;
          end
        end
        PAUSED: begin
          // Resume costs one edge: count holds while returning to RUN.
          if (!pause) begin
            state_d = RUN;
          end
        end
        EXPIRED: begin
          if (start && (reload_q != '0)) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSED);
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: one instance without and one with
// auto-reload share the same stimulus; a reference model pushes expected
// outputs per cycle into a scoreboard that is popped after each edge.
module tb_down_counter_timer;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] count0, count1;
  logic [1:0]   state0, state1;
  logic         busy0, busy1, zero0, zero1, done0, done1;

  down_counter_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .count(count0), .state(state0),
    .busy(busy0), .zero(zero0), .done(done0)
  );

  down_counter_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .count(count1), .state(state1),
    .busy(busy1), .zero(zero1), .done(done1)
  );

  typedef struct packed {
    logic [W-1:0] count;
    logic [1:0]   state;
    logic         busy;
    logic         zero;
    logic         done;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m_count [2];
  logic [W-1:0] m_reload[2];
  logic [1:0]   m_state [2];
  logic         m_done  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one timer for one rising edge.
  task automatic model(input int i, input logic r, input logic l,
                       input logic [W-1:0] lv, input logic s, input logic p);
    m_done[i] = 1'b0;
    if (r) begin
      m_count[i] = '0; m_reload[i] = '0; m_state[i] = 2'b00;
    end else if (l) begin
      m_count[i] = lv; m_reload[i] = lv; m_state[i] = 2'b00;
    end else begin
      case (m_state[i])
        2'b00: if (s && m_count[i] != 0) m_state[i] = 2'b01;
        2'b01: begin
          if (p) m_state[i] = 2'b10;
          else if (m_count[i] > 1) m_count[i] = m_count[i] - 1'b1;
          else if (m_count[i] == 1) begin
            m_done[i] = 1'b1;
            if (i == 1) m_count[i] = m_reload[i];
            else begin m_count[i] = '0; m_state[i] = 2'b11; end
          end
        end
        2'b10: if (!p) m_state[i] = 2'b01;
        default: if (s && m_reload[i] != 0) begin
          m_count[i] = m_reload[i]; m_state[i] = 2'b01;
        end
      endcase
    end
  endtask

  // Drive one cycle of stimulus, push expectations, then score both DUTs.
  task automatic step(input logic r, input logic l, input logic [W-1:0] lv,
                      input logic s, input logic p);
    exp_t e;
    @(negedge clk);
    reset = r; load = l; load_val = lv; start = s; pause = p;
    for (int i = 0; i < 2; i++) begin
      model(i, r, l, lv, s, p);
      e.count = m_count[i];
      e.state = m_state[i];
      e.busy  = (m_state[i] == 2'b01) || (m_state[i] == 2'b10);
      e.zero  = (m_count[i] == 0);
      e.done  = m_done[i];
      if (i == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    @(posedge clk);
    #1;
    e = sb0.pop_front();
    check("d0.count", count0, e.count);
    check("d0.state", state0, e.state);
    check("d0.busy",  busy0,  e.busy);
    check("d0.zero",  zero0,  e.zero);
    check("d0.done",  done0,  e.done);
    e = sb1.pop_front();
    check("ar.count", count1, e.count);
    check("ar.state", state1, e.state);
    check("ar.busy",  busy1,  e.busy);
    check("ar.zero",  zero1,  e.zero);
    check("ar.done",  done1,  e.done);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Steps until the non-reloading timer pulses done; budget bounds the wait.
  task automatic steps_to_done(input int budget, output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      n++;
    end while (!done0 && n < budget);
  endtask

  int n;
  int pulses;

  initial begin
    // Reset state
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("rst.count", count0, 0);
    check("rst.zero",  zero0, 1);
    check("rst.busy",  busy0, 0);

    // Load 5, start: done lands 5 edges after start, then DONE
    step(1'b0, 1'b1, W'(5), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("run5.busy", busy0, 1);
    steps_to_done(20, n);
    check("run5.latency", n, 5);
    check("run5.state", state0, 2'b11);
    idle(2);
    check("run5.busy_after", busy0, 0);

    // Load 6, two decrements, pause three cycles, resume: latency 6+4
    step(1'b0, 1'b1, W'(6), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
    check("pause.count_at4", count0, 4);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("pause.hold", count0, 4);
    check("pause.state", state0, 2'b10);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("pause.resume_hold", count0, 4);
    steps_to_done(20, n);
    check("pause.remaining", n, 4);

    // Auto-reload from 3: done every 3 cycles, stays in RUN
    step(1'b0, 1'b1, W'(3), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      if (done1) pulses++;
    end
    check("ar.pulses", pulses, 3);
    check("ar.state_run", state1, 2'b01);

    // Auto-reload with reload value 1: done every cycle
    step(1'b0, 1'b1, W'(1), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      if (done1) pulses++;
    end
    check("ar1.pulses", pulses, 4);

    // Load 0 then start: stays IDLE, no done
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("zero.state", state0, 2'b00);
    check("zero.zero",  zero0, 1);

    // From DONE with reload 4, start reloads and runs
    step(1'b0, 1'b1, W'(4), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    steps_to_done(20, n);
    idle(1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("restart.count", count0, 4);
    check("restart.state", state0, 2'b01);

    // Mid-run load+start wins as load; reset beats load
    step(1'b0, 1'b1, W'(5), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(3);
    check("mid.count2", count0, 2);
    step(1'b0, 1'b1, W'(9), 1'b1, 1'b0);
    check("mid.load9", count0, 9);
    check("mid.idle", state0, 2'b00);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, W'(7), 1'b1, 1'b1);
    check("mid.reset_count", count0, 0);
    check("mid.reset_state", state0, 2'b00);

    // Full-scale 15 counts down to 0 with a single done and no wrap
    step(1'b0, 1'b1, W'(15), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      if (done0) pulses++;
    end
    check("w15.pulses", pulses, 1);
    check("w15.count", count0, 0);

    // Random traffic scored against the model
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 9) == 0),
           W'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
